countdown_timer_bcd: RTL and testbench
======================================

# countdown_timer_bcd

Session countdown timer that produces the MM:SS BCD digits rendered by the VGA time/text overlay stage. It divides the system clock down to a 1 Hz tick, counts down from a preset time, and flags expiry so downstream logic can end the session. It sits directly upstream of the pixel overlay generator and shares its clock domain.

## Interface
- CLK_HZ, 40_000_000, input clock frequency in Hz; ≥ 2
- START_MIN, 5, preset minutes; 0–59
- START_SEC, 0, preset seconds; 0–59
- clk  in  1  system/pixel clock
- reset  in  1  reset (one clock domain, `clk`; reset is synchronous and active-high)
- start  in  1  one-cycle pulse; begin or resume counting
- stop  in  1  one-cycle pulse; pause counting
- load  in  1  one-cycle pulse; reload preset, return to IDLE
- tick_1Hz  out  1  one-cycle pulse on every seconds decrement
- sec_1s  out  4  seconds ones digit, BCD 0–9
- sec_10s  out  4  seconds tens digit, BCD 0–5
- min_1s  out  4  minutes ones digit, BCD 0–9
- min_10s  out  4  minutes tens digit, BCD 0–5
- running  out  1  high only in RUN
- expired  out  1  high only in DONE; sticky until load or reset

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Reset and load values:
  - Digits = preset BCD, e.g. 05:00 gives min_10s=0, min_1s=5, sec_10s=0, sec_1s=0.
  - Prescaler = 0; tick_1Hz=0; running=0; expired=0.
- Command priority within a cycle: reset > load > stop > start.
- IDLE:
  - start → RUN.
  - If the preset is 00:00, start → DONE instead.
- RUN:
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - On wrap, the digits decrement by one second.
  - stop → PAUSE.
- PAUSE:
  - Prescaler and digits are held; the partial second is preserved.
  - start → RUN. stop is ignored.
- DONE:
  - Digits hold at 00:00. start and stop are ignored.
  - Only load or reset leave DONE, both to IDLE.
- Load applies in any state.
- BCD decrement is a borrow chain:
  - sec_1s 0→9 borrows from sec_10s.
  - sec_10s 0→5 borrows from min_1s.
  - min_1s 0→9 borrows from min_10s.
  - min_10s never underflows, because DONE is entered first.
- A decrement that produces 00:00 moves RUN→DONE in the same update. expired rises with the 00:00 digits.
- Every digit stays within its BCD range at all times.
- Prescaler width is $clog2(CLK_HZ). The comparison is against CLK_HZ-1 at full width, with no truncation.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Commands take effect on the next cycle:
  - A start sampled at edge N gives running=1 after edge N.
  - The prescaler counts from edge N+1.
- The first tick from a fresh start comes CLK_HZ cycles after running rises.
- A seconds decrement in RUN:
  - The prescaler reaches CLK_HZ-1 at edge M.
  - After edge M+1: the new digits and tick_1Hz=1 appear together for exactly one cycle.
- stop on the same edge as a prescaler wrap: stop wins. No decrement and no tick; the prescaler holds at CLK_HZ-1. The next start followed by one RUN edge produces the tick.
- load on the same edge as the final decrement: the preset is loaded, state goes to IDLE, and expired stays 0.
- start held high for several cycles acts as a single start. Re-sampling in RUN has no effect.
- tick_1Hz is never asserted outside RUN→RUN or RUN→DONE transitions.

## Structure
- Package `timer_pkg`:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - BCD digit typedef (4 bits).
  - Digit modulus constants (9, 5).
  - Function converting a 0–59 integer to two BCD digits, used for the preset.
- Sub-module `bcd_digit_down`:
  - Parameter MAX (9 or 5).
  - Ports: clk, reset, load, load_val, dec_en, borrow_out (asserted when the digit is 0 and dec_en=1).
  - Instantiated four times in a chain.
- Elaboration-time checks: START_MIN ≤ 59, START_SEC ≤ 59, CLK_HZ ≥ 2.

## Test plan
Run with CLK_HZ=4, START_MIN=1, START_SEC=2 unless stated.
- Reset → digits 01:02, running=0, expired=0, tick_1Hz=0. Outputs hold over 20 idle cycles.
- Pulse start:
  - running=1 on the next cycle.
  - First tick 4 cycles later with 01:01, then 01:00.
  - Next tick gives 00:59, exercising the sec_10s and min_1s borrows.
- Run to the end (62 ticks) → 00:00, expired=1, running=0 in the same cycle as the final tick. Later start pulses do not change state.
- Pause and resume:
  - stop after 2 prescaler cycles; hold 10 cycles, during which digits and ticks are frozen.
  - start → the next tick arrives 2 cycles after resume.
- Collisions:
  - stop and start on the same edge → PAUSE.
  - load and start on the same edge → IDLE at 01:02.
  - load on the final-decrement edge → IDLE, expired=0.
- Preset and reset edge cases:
  - START_MIN=0, START_SEC=0 → start goes directly to DONE with no tick.
  - reset asserted mid-RUN at 00:37 → 01:02, IDLE, prescaler 0.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types, digit limits and the preset conversion helper
//                for the MM:SS BCD countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Timer modes; the encoding is fixed so the state register width is known.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Largest value each digit position can hold.
    localparam int unsigned c_ONES_MAX = 9;
    localparam int unsigned c_TENS_MAX = 5;

    // Converts a 0-59 value into {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd2(input int unsigned value);
        return {bcd_t'(value / 10), bcd_t'(value % 10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_down.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_down
//  Description : One BCD digit of a down-counting borrow chain. Wraps from 0
//                to MAX on a decrement and signals a borrow to the next digit.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                load        - reload load_val (same effect as reset)
//                load_val    - value restored on reset/load
//                dec_en      - decrement this digit on the next edge
//                borrow_out  - dec_en while the digit is 0 (combinational)
//                digit       - registered digit value
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t load_val,
    input  logic dec_en,
    output logic borrow_out,
    output bcd_t digit
);

    localparam bcd_t c_MAX = bcd_t'(MAX);

    bcd_t r_digit;

    // Reset returns to the preset rather than zero so the whole timer comes
    // out of reset showing the session length.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_digit <= load_val;
        end else if (dec_en) begin
            r_digit <= (r_digit == 4'd0) ? c_MAX : r_digit - 4'd1;
        end
    end

    assign borrow_out = dec_en && (r_digit == 4'd0);
    assign digit      = r_digit;

endmodule
`default_nettype wire

// File: rtl/countdown_timer_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_bcd
//  Description : MM:SS session countdown timer for the VGA overlay. Divides
//                clk down to a 1 Hz tick, decrements a four-digit BCD chain
//                and flags expiry at 00:00.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start / stop / load - one-cycle command pulses
//                tick_1Hz            - pulse on every seconds decrement
//                sec_1s .. min_10s   - BCD digits of the remaining time
//                running / expired   - high in RUN / high in DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_bcd
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 40_000_000,
    parameter int unsigned START_MIN = 5,
    parameter int unsigned START_SEC = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    output logic       tick_1Hz,
    output logic [3:0] sec_1s,
    output logic [3:0] sec_10s,
    output logic [3:0] min_1s,
    output logic [3:0] min_10s,
    output logic       running,
    output logic       expired
);

    if (CLK_HZ < 2) begin : g_chk_clk_hz
        $error("countdown_timer_bcd: CLK_HZ must be at least 2");
    end
    if (START_MIN > 59) begin : g_chk_start_min
        $error("countdown_timer_bcd: START_MIN must be 0..59");
    end
    if (START_SEC > 59) begin : g_chk_start_sec
        $error("countdown_timer_bcd: START_SEC must be 0..59");
    end

    // Guarded so an illegal CLK_HZ reports the check above instead of a
    // zero-width vector.
    localparam int unsigned         c_PS_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    // CLK_HZ-1 is always below 2**c_PS_W, so this cast keeps every bit.
    localparam logic [c_PS_W-1:0]   c_PS_MAX = c_PS_W'(CLK_HZ - 1);
    localparam logic [c_PS_W-1:0]   c_PS_ONE = c_PS_W'(1);
    // Digit order, low nibble first: sec_1s, sec_10s, min_1s, min_10s.
    localparam logic [15:0]         c_PRESET = {to_bcd2(START_MIN), to_bcd2(START_SEC)};
    localparam logic                c_PRESET_ZERO = (c_PRESET == 16'd0);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_PS_W-1:0]   r_prescale;
    logic                r_tick;
    logic                r_running;
    logic                r_expired;
    logic                w_wrap;
    logic                w_last;
    logic                w_dec;
    logic                w_tick_d;
    logic                w_running_d;
    logic                w_expired_d;
    logic [4:0]          w_borrow;
    logic [15:0]         w_digits;
    logic                w_borrow_unused;

    assign w_wrap = (r_prescale == c_PS_MAX);
    // 00:01 is the only value whose decrement lands on 00:00.
    assign w_last = (w_digits == 16'h0001);
    // load and stop both outrank the decrement on a wrap edge.
    assign w_dec  = (r_state == ST_RUN) && !load && !stop && w_wrap;

    assign w_borrow[0] = w_dec;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_down #(
            .MAX ((i % 2 == 0) ? c_ONES_MAX : c_TENS_MAX)
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_val   (c_PRESET[4*i +: 4]),
            .dec_en     (w_borrow[i]),
            .borrow_out (w_borrow[i+1]),
            .digit      (w_digits[4*i +: 4])
        );
    end

    // min_10s never borrows: DONE is entered at 00:00 before it could.
    assign w_borrow_unused = w_borrow[4];

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tick    <= w_tick_d;
            r_running <= w_running_d;
            r_expired <= w_expired_d;
        end
    end

    // Prescaler only advances on RUN edges without a stop, so a pause keeps
    // the partial second, including a pending wrap at CLK_HZ-1.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_prescale <= '0;
        end else if ((r_state == ST_RUN) && !stop) begin
            r_prescale <= w_wrap ? '0 : r_prescale + c_PS_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Next state: load > stop > start
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (load) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!stop && start) begin
                        w_state_next = c_PRESET_ZERO ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_next = ST_PAUSE;
                    end else if (w_wrap && w_last) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (!stop && start) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so the flags line up with the
    // digits that are updated on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_tick_d    = w_dec;
        w_running_d = (w_state_next == ST_RUN);
        w_expired_d = (w_state_next == ST_DONE);
    end

    assign tick_1Hz = r_tick;
    assign running  = r_running;
    assign expired  = r_expired;
    assign sec_1s   = w_digits[3:0];
    assign sec_10s  = w_digits[7:4];
    assign min_1s   = w_digits[11:8];
    assign min_10s  = w_digits[15:12];

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_bcd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer_bcd
//  Description : Self-checking bench for countdown_timer_bcd. A reference
//                model tracks remaining time as an integer count of seconds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_bcd;

    localparam int unsigned CLK_HZ    = 4;
    localparam int unsigned START_MIN = 1;
    localparam int unsigned START_SEC = 2;
    localparam int          PRESET    = START_MIN * 60 + START_SEC;
    localparam int          M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic load  = 1'b0;

    logic       tick_1Hz, running, expired;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s;
    logic       z_tick, z_running, z_expired;
    logic [3:0] z_s1, z_s10, z_m1, z_m10;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    countdown_timer_bcd #(
        .CLK_HZ(CLK_HZ), .START_MIN(START_MIN), .START_SEC(START_SEC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .tick_1Hz(tick_1Hz), .sec_1s(sec_1s), .sec_10s(sec_10s),
        .min_1s(min_1s), .min_10s(min_10s), .running(running), .expired(expired)
    );

    countdown_timer_bcd #(
        .CLK_HZ(CLK_HZ), .START_MIN(0), .START_SEC(0)
    ) dut_zero (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .tick_1Hz(z_tick), .sec_1s(z_s1), .sec_10s(z_s10),
        .min_1s(z_m1), .min_10s(z_m10), .running(z_running), .expired(z_expired)
    );

    logic [18:0] obs;
    logic [18:0] z_obs;
    assign obs   = {tick_1Hz, running, expired, min_10s, min_1s, sec_10s, sec_1s};
    assign z_obs = {z_tick, z_running, z_expired, z_m10, z_m1, z_s10, z_s1};

    // ------------------------------------------------------------------
    // Reference model: remaining seconds, sub-second phase and mode.
    // ------------------------------------------------------------------
    int m_rem   = PRESET;
    int m_phase = 0;
    int m_mode  = M_IDLE;
    bit m_tick  = 1'b0;

    always @(posedge clk) begin
        m_tick = 1'b0;
        if (reset || load) begin
            m_mode  = M_IDLE;
            m_rem   = PRESET;
            m_phase = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (!stop && start) m_mode = (PRESET == 0) ? M_DONE : M_RUN;
                M_RUN: begin
                    if (stop) begin
                        m_mode = M_PAUSE;
                    end else if (m_phase == CLK_HZ - 1) begin
                        m_phase = 0;
                        m_rem   = m_rem - 1;
                        m_tick  = 1'b1;
                        if (m_rem == 0) m_mode = M_DONE;
                    end else begin
                        m_phase = m_phase + 1;
                    end
                end
                M_PAUSE: if (!stop && start) m_mode = M_RUN;
                default: ;
            endcase
        end
    end

    function automatic logic [18:0] m_vec();
        int mins = m_rem / 60;
        int secs = m_rem % 60;
        return {m_tick, (m_mode == M_RUN), (m_mode == M_DONE),
                4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    endfunction

    // Drive one set of command inputs across one rising edge, then return at
    // the following falling edge where outputs are stable.
    task automatic step(input logic s, input logic p, input logic l, input logic r);
        start = s; stop = p; load = l; reset = r;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        step(0, 0, 0, 1);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL reset_state: got %h expected %h", obs, {3'b000, 16'h0102});
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (obs !== {3'b000, 16'h0102}) begin
                n_errors++; $display("FAIL idle_hold[%0d]: got %h expected %h", i, obs, {3'b000, 16'h0102});
            end
        end
    endtask

    task automatic test_start_borrow();
        logic [15:0] want [3];
        want[0] = 16'h0101; want[1] = 16'h0100; want[2] = 16'h0059;
        step(1, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b010, 16'h0102}) begin
            n_errors++; $display("FAIL start_running: got %h expected %h", obs, {3'b010, 16'h0102});
        end
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c < 3; c++) begin
                step(0, 0, 0, 0);
                n_checks++;
                if (obs !== {3'b010, want[t] == 16'h0101 ? 16'h0102 : (t == 1 ? 16'h0101 : 16'h0100)}) begin
                    n_errors++; $display("FAIL tick_wait[%0d.%0d]: got %h", t, c, obs);
                end
            end
            step(0, 0, 0, 0);
            n_checks++;
            if (obs !== {3'b110, want[t]}) begin
                n_errors++; $display("FAIL tick_digits[%0d]: got %h expected %h", t, obs, {3'b110, want[t]});
            end
        end
    endtask

    task automatic test_run_to_end();
        bit reached = 1'b0;
        int budget  = 0;
        while (!reached && budget < 400) begin
            step(0, 0, 0, 0);
            budget++;
            n_checks++;
            if (obs !== m_vec()) begin
                n_errors++; $display("FAIL run_model[%0d]: got %h expected %h", budget, obs, m_vec());
            end
            if (m_mode == M_DONE) reached = 1'b1;
        end
        n_checks++;
        if (!reached) begin
            n_errors++; $display("FAIL run_end_timeout: got no expiry after %0d cycles, expected expiry", budget);
        end else if (obs !== {3'b101, 16'h0000}) begin
            n_errors++; $display("FAIL final_tick: got %h expected %h", obs, {3'b101, 16'h0000});
        end
        for (int i = 0; i < 6; i++) begin
            step((i % 2) == 0, (i == 3), 0, 0);
            n_checks++;
            if (obs !== {3'b001, 16'h0000}) begin
                n_errors++; $display("FAIL done_sticky[%0d]: got %h expected %h", i, obs, {3'b001, 16'h0000});
            end
        end
    endtask

    task automatic test_pause_resume();
        step(0, 0, 1, 0);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL load_idle: got %h expected %h", obs, {3'b000, 16'h0102});
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL stop_pause: got %h expected %h", obs, {3'b000, 16'h0102});
        end
        for (int i = 0; i < 10; i++) begin
            step(0, (i == 4), 0, 0);
            n_checks++;
            if (obs !== {3'b000, 16'h0102}) begin
                n_errors++; $display("FAIL pause_frozen[%0d]: got %h expected %h", i, obs, {3'b000, 16'h0102});
            end
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b010, 16'h0102}) begin
            n_errors++; $display("FAIL resume: got %h expected %h", obs, {3'b010, 16'h0102});
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b010, 16'h0102}) begin
            n_errors++; $display("FAIL resume_wait: got %h expected %h", obs, {3'b010, 16'h0102});
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b110, 16'h0101}) begin
            n_errors++; $display("FAIL resume_tick: got %h expected %h", obs, {3'b110, 16'h0101});
        end
    endtask

    task automatic test_collisions();
        int budget;
        step(1, 1, 0, 0);
        n_checks++;
        if (obs !== {3'b000, 16'h0101}) begin
            n_errors++; $display("FAIL stop_start_edge: got %h expected %h", obs, {3'b000, 16'h0101});
        end
        step(1, 0, 1, 0);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL load_start_edge: got %h expected %h", obs, {3'b000, 16'h0102});
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL load_start_idle: got %h expected %h", obs, {3'b000, 16'h0102});
        end
        // stop on the wrap edge: no decrement, tick comes one RUN edge after resume
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL stop_on_wrap: got %h expected %h", obs, {3'b000, 16'h0102});
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b110, 16'h0101}) begin
            n_errors++; $display("FAIL wrap_tick_after_resume: got %h expected %h", obs, {3'b110, 16'h0101});
        end
        // load on the edge of the final decrement
        budget = 0;
        while (!(m_rem == 1 && m_phase == CLK_HZ - 1) && budget < 400) begin
            step(0, 0, 0, 0);
            budget++;
            n_checks++;
            if (obs !== m_vec()) begin
                n_errors++; $display("FAIL approach_model[%0d]: got %h expected %h", budget, obs, m_vec());
            end
        end
        step(0, 0, 1, 0);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL load_on_final: got %h expected %h", obs, {3'b000, 16'h0102});
        end
    endtask

    task automatic test_reset_mid_run();
        int budget = 0;
        step(1, 0, 0, 0);
        while (m_rem != 37 && budget < 200) begin
            step(0, 0, 0, 0);
            budget++;
        end
        n_checks++;
        if (obs !== {3'b110, 16'h0037}) begin
            n_errors++; $display("FAIL reach_0037: got %h expected %h", obs, {3'b110, 16'h0037});
        end
        step(0, 0, 0, 1);
        n_checks++;
        if (obs !== {3'b000, 16'h0102}) begin
            n_errors++; $display("FAIL reset_mid_run: got %h expected %h", obs, {3'b000, 16'h0102});
        end
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b010, 16'h0102}) begin
            n_errors++; $display("FAIL reset_prescale_wait: got %h expected %h", obs, {3'b010, 16'h0102});
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (obs !== {3'b110, 16'h0101}) begin
            n_errors++; $display("FAIL reset_prescale_zero: got %h expected %h", obs, {3'b110, 16'h0101});
        end
    endtask

    task automatic test_zero_preset();
        step(0, 0, 0, 1);
        n_checks++;
        if (z_obs !== {3'b000, 16'h0000}) begin
            n_errors++; $display("FAIL zero_reset: got %h expected %h", z_obs, {3'b000, 16'h0000});
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (z_obs !== {3'b001, 16'h0000}) begin
            n_errors++; $display("FAIL zero_start_done: got %h expected %h", z_obs, {3'b001, 16'h0000});
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (z_obs !== {3'b001, 16'h0000}) begin
                n_errors++; $display("FAIL zero_no_tick[%0d]: got %h expected %h", i, z_obs, {3'b001, 16'h0000});
            end
        end
    endtask

    task automatic test_random();
        step(0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 95) == 0, $urandom_range(0, 199) == 0);
            n_checks++;
            if (obs !== m_vec()) begin
                n_errors++; $display("FAIL random_model[%0d]: got %h expected %h", i, obs, m_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_borrow();
        test_run_to_end();
        test_pause_resume();
        test_collisions();
        test_reset_mid_run();
        test_zero_preset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
